arb_m2s1: RTL and testbench
===========================

// Module: arb_m2s1
// PURPOSE
// - Converging counterpart of the 1-master/2-slave address splitter: merges two masters (m0, m1) onto one slave port (s).
// - Round-robin arbitration on the request channel; in-order read-response routing back to the issuing master.
// - Sits at bus level where two cores, or a core and a DMA, share one memory or peripheral slave.
// PARAMETERS
// - RD_DEPTH      4  max outstanding reads tracked; power of 2, >=2
// - RD_DEPTH_LOG  2  log2(RD_DEPTH); pointer width
// PORTS
// - clk_i      in   1   clock; all state on rising edge
// - rst_i      in   1   reset, asynchronous assert, active-low
// - m0_req     in   1   m0 request valid; held with all fields stable until m0_ack
// - m0_we      in   1   1=write, 0=read
// - m0_addr    in   32  byte address
// - m0_be      in   4   byte enables
// - m0_wdata   in   32  write data
// - m0_ack     out  1   m0 request accepted this cycle
// - m0_resp    out  1   read data valid for m0
// - m0_rdata   out  32  read data (driven from s_rdata regardless of owner)
// - m1_*       same set and meaning as m0_*, for master 1
// - s_req/s_we/s_addr/s_be/s_wdata  out  1/1/32/4/32  muxed request to slave
// - s_ack      in   1   slave accepted s_req
// - s_resp     in   1   slave read data valid; reads only, strictly in order
// - s_rdata    in   32  slave read data
// BEHAVIOUR
// - Handshake: transfer happens in a cycle with req&ack. Writes produce no resp; each read produces one resp, in issue order.
// - Arbitration (combinational): rr_q names the priority master. Grant goes to rr_q if requesting, otherwise to the other master.
// - rr_q updates only on accepted transfer (s_req&s_ack): rr_q <= ~granted id. This keeps the grant stable while a master waits.
// - Request path, zero latency: s_* = granted master's fields; s_req = granted req & ~block.
// - block = granted is a read & fifo full. No push-when-full, even if a pop occurs in the same cycle.
// - mX_ack = s_ack & s_req & (grant==X). Non-granted master ack=0.
// - Read tracking: id FIFO (RD_DEPTH x 1b). Push granted id on an accepted read. Pop on s_resp.
// - Response path, zero latency: mX_resp = s_resp & ~empty & (head==X).
// - s_resp with FIFO empty: dropped; no mX_resp; no state change.
// - Simultaneous push and pop: both take effect; count unchanged; pointers wrap modulo RD_DEPTH.
// - Writes never touch the FIFO and are accepted even when it is full.
// - Reset (rst_i=0, any time): rr_q=0 (m0 priority), FIFO empty, pointers 0.
// - Outputs during/after reset are purely combinational from inputs: with no req, s_req=0, m0/m1 ack=0, resp=0.
// - Slave responses for reads in flight before a reset are dropped.
// - No internal timeouts. Behaviour with unstable held requests is undefined.
// STRUCTURE
// - Shared package (mpss_bus_pkg): ADDR_W=32, DATA_W=32, BE_W=4, master-id type (1b), MASTER_0/MASTER_1 constants.
// - Sub-module arb_id_fifo: sync FIFO, width 1, depth RD_DEPTH.
//   - Ports: clk_i, rst_i, push, din, pop, dout, full, empty. Registered pointers plus count.
// - Top: rr_q flop, grant logic, request mux, ack/resp demux.
// TESTING
// - Single master: m0 read addr 0x100, s_ack same cycle -> m0_ack=1 that cycle, m1_ack=0.
//   Then s_resp rdata 0xDEADBEEF -> m0_resp=1, m0_rdata=0xDEADBEEF, m1_resp=0.
// - Contention: m0 and m1 hold req continuously, s_ack=1.
//   -> after reset acks alternate m0,m1,m0,m1; s_addr tracks the granted master.
// - Stall fairness: both request, s_ack=0 for 5 cycles -> s_addr stays m0's address. Then s_ack=1 -> m0 acked, next grant m1.
// - Ordering: reads m0,m1,m1,m0 accepted; 4 s_resp with 1..4.
//   -> resp order m0(1), m1(2), m1(3), m0(4); FIFO empty at end.
// - Full: RD_DEPTH=4, 4 reads outstanding.
//   -> 5th read sees s_req=0 and no ack. A concurrent write is acked.
//   -> one s_resp then unblocks the read the following cycle.
// - Reset mid-flight: 2 reads outstanding, rst_i=0 then 1, then 2 stray s_resp -> no mX_resp; next m1-only request acked at once.

Source files
------------

// File: rtl/mpss_bus_pkg.sv
// Shared bus definitions for the two-master / one-slave merge point:
// field widths, master identifiers and a small helper for id flipping.
package mpss_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } mid_t;

    function automatic mid_t other_master(input mid_t id);
        return (id == MASTER_0) ? MASTER_1 : MASTER_0;
    endfunction

endpackage

// File: rtl/arb_m2s1_if.sv
// One request/response bus port. The "master" modport is the side that
// issues requests; the "slave" modport is the side that accepts them.
interface arb_m2s1_if;

    logic                              req;
    logic                              we;
    logic [mpss_bus_pkg::ADDR_W-1:0]   addr;
    logic [mpss_bus_pkg::BE_W-1:0]     be;
    logic [mpss_bus_pkg::DATA_W-1:0]   wdata;
    logic                              ack;
    logic                              resp;
    logic [mpss_bus_pkg::DATA_W-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/arb_id_fifo.sv
// Tracks which master issued each outstanding read so responses can be
// routed back in issue order. One bit per entry; registered pointers plus
// an occupancy count so full/empty are simple compares.
module arb_id_fifo #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    logic [DEPTH-1:0]     mem;
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   count;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is refused even if a pop lands the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (DEPTH_LOG + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_m2s1.sv
// Merges two masters onto one slave. Round-robin grant on the request
// channel, in-order routing of read responses back to the issuer.
// Request and response paths are purely combinational; the only state is
// the priority pointer and the outstanding-read id FIFO.
module arb_m2s1
    import mpss_bus_pkg::*;
#(
    parameter int RD_DEPTH     = 4,
    parameter int RD_DEPTH_LOG = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    arb_m2s1_if.slave   m0,
    arb_m2s1_if.slave   m1,
    arb_m2s1_if.master  s
);

    mid_t rr_q;
    mid_t grant;
    mid_t head;
    logic g_req;
    logic g_we;
    logic block;
    logic accept;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_dout;

    // Priority master wins if requesting, otherwise the other one gets it.
    always_comb begin
        grant = rr_q;
        if (rr_q == MASTER_0) begin
            if (!m0.req) grant = MASTER_1;
        end else begin
            if (!m1.req) grant = MASTER_0;
        end
    end

    // Forward the granted master's request fields to the slave.
    always_comb begin
        g_req   = m0.req;
        g_we    = m0.we;
        s.addr  = m0.addr;
        s.be    = m0.be;
        s.wdata = m0.wdata;
        if (grant == MASTER_1) begin
            g_req   = m1.req;
            g_we    = m1.we;
            s.addr  = m1.addr;
            s.be    = m1.be;
            s.wdata = m1.wdata;
        end
    end

    // Reads stall while the id FIFO is full; writes pass regardless.
    assign block  = g_req & ~g_we & fifo_full;
    assign s.req  = g_req & ~block;
    assign s.we   = g_we;
    assign accept = s.req & s.ack;

    assign m0.ack = accept & (grant == MASTER_0);
    assign m1.ack = accept & (grant == MASTER_1);

    assign fifo_push = accept & ~g_we;
    assign fifo_pop  = s.resp & ~fifo_empty;
    assign head      = mid_t'(fifo_dout);

    // Responses with nothing outstanding are dropped silently.
    assign m0.resp  = fifo_pop & (head == MASTER_0);
    assign m1.resp  = fifo_pop & (head == MASTER_1);
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;

    // Priority moves only on an accepted transfer, so a waiting grant holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q <= MASTER_0;
        end else if (accept) begin
            rr_q <= other_master(grant);
        end
    end

    arb_id_fifo #(
        .DEPTH     (RD_DEPTH),
        .DEPTH_LOG (RD_DEPTH_LOG)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .din   (logic'(grant)),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_arb_m2s1.sv
// Bench for arb_m2s1: table of single-cycle arbitration vectors plus
// hand-written multi-cycle sequences; read responses are checked against
// a queue of expected master ids filled as reads are issued.
module tb_arb_m2s1;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;
    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_1111;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    arb_m2s1_if m0_bus ();
    arb_m2s1_if m1_bus ();
    arb_m2s1_if s_bus ();

    arb_m2s1 #(
        .RD_DEPTH     (4),
        .RD_DEPTH_LOG (2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    int total = 0;
    int bad   = 0;
    bit sb_q[$];

    typedef struct {
        logic        m0_req;
        logic        m1_req;
        logic        s_ack;
        logic        e_sreq;
        logic        e_m0ack;
        logic        e_m1ack;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic drv_m0(input logic req, input logic we, input logic [31:0] addr);
        m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr;
        m0_bus.be = 4'hF; m0_bus.wdata = D0;
    endtask

    task automatic drv_m1(input logic req, input logic we, input logic [31:0] addr);
        m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr;
        m1_bus.be = 4'h3; m1_bus.wdata = D1;
    endtask

    task automatic idle();
        drv_m0(1'b0, 1'b0, A0);
        drv_m1(1'b0, 1'b0, A1);
        s_bus.ack = 1'b0;
        s_bus.resp = 1'b0;
        s_bus.rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        sb_q.delete();
        tick();
    endtask

    // Call after settle() with s_resp asserted: compares routing against the queue head.
    task automatic sb_check(input string name, input logic [31:0] val);
        bit id;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: response seen with empty scoreboard", name);
        end else begin
            id = sb_q.pop_front();
            chk({name, "_m0resp"}, 32'(m0_bus.resp), 32'(id == 1'b0));
            chk({name, "_m1resp"}, 32'(m1_bus.resp), 32'(id == 1'b1));
            chk({name, "_rdata"}, (id ? m1_bus.rdata : m0_bus.rdata), val);
        end
    endtask

    task automatic resp_cycle(input string name, input logic [31:0] val);
        s_bus.resp = 1'b1;
        s_bus.rdata = val;
        settle();
        sb_check(name, val);
        tick();
        s_bus.resp = 1'b0;
    endtask

    task automatic read_accept(input bit id, input string name);
        drv_m0(id == 1'b0, 1'b0, A0);
        drv_m1(id == 1'b1, 1'b0, A1);
        s_bus.ack = 1'b1;
        settle();
        chk({name, "_m0ack"}, 32'(m0_bus.ack), 32'(id == 1'b0));
        chk({name, "_m1ack"}, 32'(m1_bus.ack), 32'(id == 1'b1));
        sb_q.push_back(id);
        tick();
        idle();
    endtask

    initial begin
        bit ord[4];

        // Writes from both masters; rr starts at m0 after reset.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, A0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, A1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, A0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, A1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, A1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, A0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A1};

        // Reset state: outputs quiet even with a stray slave response.
        idle();
        rst_i = 1'b0;
        s_bus.resp = 1'b1;
        settle();
        chk("rst_sreq", 32'(s_bus.req), 32'd0);
        chk("rst_m0ack", 32'(m0_bus.ack), 32'd0);
        chk("rst_m1ack", 32'(m1_bus.ack), 32'd0);
        chk("rst_m0resp", 32'(m0_bus.resp), 32'd0);
        chk("rst_m1resp", 32'(m1_bus.resp), 32'd0);
        do_reset();

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            drv_m0(vecs[i].m0_req, 1'b1, A0);
            drv_m1(vecs[i].m1_req, 1'b1, A1);
            s_bus.ack = vecs[i].s_ack;
            settle();
            chk($sformatf("vec%0d_sreq", i), 32'(s_bus.req), 32'(vecs[i].e_sreq));
            chk($sformatf("vec%0d_m0ack", i), 32'(m0_bus.ack), 32'(vecs[i].e_m0ack));
            chk($sformatf("vec%0d_m1ack", i), 32'(m1_bus.ack), 32'(vecs[i].e_m1ack));
            if (vecs[i].e_sreq) begin
                chk($sformatf("vec%0d_saddr", i), s_bus.addr, vecs[i].e_addr);
                chk($sformatf("vec%0d_swdata", i), s_bus.wdata,
                    (vecs[i].e_addr == A0) ? D0 : D1);
            end
            tick();
        end
        idle();

        // Single master read and its response.
        do_reset();
        drv_m0(1'b1, 1'b0, 32'h100);
        s_bus.ack = 1'b1;
        settle();
        chk("single_m0ack", 32'(m0_bus.ack), 32'd1);
        chk("single_m1ack", 32'(m1_bus.ack), 32'd0);
        chk("single_saddr", s_bus.addr, 32'h100);
        chk("single_swe", 32'(s_bus.we), 32'd0);
        sb_q.push_back(1'b0);
        tick();
        idle();
        resp_cycle("single_resp", 32'hDEADBEEF);

        // Stall fairness: m0 holds grant through 5 stalled cycles.
        do_reset();
        drv_m0(1'b1, 1'b0, A0);
        drv_m1(1'b1, 1'b0, A1);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("stall%0d_saddr", i), s_bus.addr, A0);
            chk($sformatf("stall%0d_ack", i), 32'({m0_bus.ack, m1_bus.ack}), 32'd0);
            tick();
        end
        s_bus.ack = 1'b1;
        settle();
        chk("stall_rel_m0ack", 32'(m0_bus.ack), 32'd1);
        sb_q.push_back(1'b0);
        tick();
        settle();
        chk("stall_next_saddr", s_bus.addr, A1);
        chk("stall_next_m1ack", 32'(m1_bus.ack), 32'd1);
        sb_q.push_back(1'b1);
        tick();
        idle();
        resp_cycle("stall_r0", 32'h5A5A_0001);
        resp_cycle("stall_r1", 32'h5A5A_0002);

        // Ordering: m0, m1, m1, m0.
        ord[0] = 1'b0; ord[1] = 1'b1; ord[2] = 1'b1; ord[3] = 1'b0;
        for (int i = 0; i < 4; i++) read_accept(ord[i], $sformatf("ord%0d", i));
        for (int i = 0; i < 4; i++) resp_cycle($sformatf("ord_r%0d", i), 32'(i + 1));
        s_bus.resp = 1'b1;
        settle();
        chk("ord_empty_resp", 32'({m0_bus.resp, m1_bus.resp}), 32'd0);
        tick();
        s_bus.resp = 1'b0;

        // Full FIFO blocks reads but not writes.
        for (int i = 0; i < 4; i++) read_accept(1'b0, $sformatf("fill%0d", i));
        drv_m0(1'b1, 1'b0, A0);
        s_bus.ack = 1'b1;
        settle();
        chk("full_sreq", 32'(s_bus.req), 32'd0);
        chk("full_m0ack", 32'(m0_bus.ack), 32'd0);
        tick();
        drv_m1(1'b1, 1'b1, A1);
        settle();
        chk("full_wr_sreq", 32'(s_bus.req), 32'd1);
        chk("full_wr_swe", 32'(s_bus.we), 32'd1);
        chk("full_wr_m1ack", 32'(m1_bus.ack), 32'd1);
        chk("full_wr_m0ack", 32'(m0_bus.ack), 32'd0);
        tick();
        drv_m1(1'b0, 1'b0, A1);
        s_bus.resp = 1'b1;
        s_bus.rdata = 32'h0000_0011;
        settle();
        chk("full_pop_sreq", 32'(s_bus.req), 32'd0);
        chk("full_pop_m0ack", 32'(m0_bus.ack), 32'd0);
        sb_check("full_pop", 32'h0000_0011);
        tick();
        s_bus.resp = 1'b0;
        settle();
        chk("unblock_sreq", 32'(s_bus.req), 32'd1);
        chk("unblock_m0ack", 32'(m0_bus.ack), 32'd1);
        sb_q.push_back(1'b0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) resp_cycle($sformatf("drain%0d", i), 32'h100 + 32'(i));

        // Reset with reads in flight.
        read_accept(1'b0, "mid0");
        read_accept(1'b0, "mid1");
        rst_i = 1'b0;
        settle();
        chk("mid_rst_sreq", 32'(s_bus.req), 32'd0);
        tick();
        rst_i = 1'b1;
        sb_q.delete();
        tick();
        for (int i = 0; i < 2; i++) begin
            s_bus.resp = 1'b1;
            settle();
            chk($sformatf("stray%0d_resp", i), 32'({m0_bus.resp, m1_bus.resp}), 32'd0);
            tick();
        end
        s_bus.resp = 1'b0;
        read_accept(1'b1, "post_rst");
        resp_cycle("post_rst_r", 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
